// File: rtl/bcd_display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ERR   = 7'h79;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder; 10-15 show 'E'.
// Latency: 0 cycles.
// Backpressure: none.
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure table lookup.
    always_comb begin
        seg = glyph(nib);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Captures a BCD digit array on load and scans it onto a shared 7-seg bus with gaps.
// Latency: digit 0 reaches the pins two edges after the load edge; pins are registered.
// Backpressure: none; load is accepted whenever en=1 and clear=0, en=0 freezes everything.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int GAP_CYCLES     = 500,
    parameter bit ACTIVE_LOW     = 1'b1,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit CHECK_PARAM    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [3:0]            bcd [NUM_DIGITS],
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  valid
);

    localparam int CNT_MAX = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam int IW      = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    if (CHECK_PARAM && (NUM_DIGITS < 1 || REFRESH_CYCLES < 1)) begin : g_param_err
        $fatal(1, "bcd_display_scanner: NUM_DIGITS and REFRESH_CYCLES must be >= 1");
    end

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, idx_nxt;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            hold_q [NUM_DIGITS];
    logic [3:0]            hold_d [NUM_DIGITS];
    logic                  valid_q, valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [6:0]            seg_hi;
    logic [6:0]            dig_seg;
    logic                  lit;

    bcd_to_7seg u_dec (
        .nib (hold_q[idx_q]),
        .seg (dig_seg)
    );

    // A position is a leading zero when it and every higher position hold zero; position 0 always shows.
    always_comb begin : p_blank
        logic lz;
        lz    = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz       = lz & (hold_q[i] == 4'd0);
            blank[i] = BLANK_LZ && (i > 0) && lz;
        end
    end

    // Scan FSM: dwell on each digit, optional dark gap, then advance; loads never restart the scan.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (en) begin
            if (clear) begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                if (load) begin
                    hold_d  = bcd;
                    valid_d = 1'b1;
                end
                unique case (state_q)
                    IDLE: begin
                        if (load) begin
                            state_d = SHOW;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end
                    end
                    SHOW: begin
                        if (cnt_q == REF_LAST) begin
                            cnt_d = '0;
                            if (GAP_CYCLES == 0) begin
                                idx_d = idx_nxt;
                            end else begin
                                state_d = GAP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            state_d = SHOW;
                            idx_d   = idx_nxt;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Pin drive from the current scan position; clear darkens the pins on the same edge.
    always_comb begin
        lit    = (state_q == SHOW) && !blank[idx_q];
        an_hi  = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_hi = lit ? dig_seg : SEG_BLANK;
        seg_d  = seg_q;
        an_d   = an_q;
        if (en) begin
            if (clear) begin
                seg_d = SEG_OFF;
                an_d  = AN_OFF;
            end else begin
                seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
                an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
            end
        end
    end

    // State, hold register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hold_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            hold_q  <= hold_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: vector table, corner sequences, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_display_scanner;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n, en, clear, load;
    logic [3:0] bcd [N];
    logic [6:0] seg;
    logic [3:0] an;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a scan is just "cycles since the scan started".
    bit         m_act;
    int         m_t;
    logic [3:0] m_hold [N];
    logic       m_valid;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  lit;
        logic [27:0] segs;
    } vec_t;

    vec_t       vt [6];
    logic [3:0] slot_an [21];

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .NUM_DIGITS     (N),
        .REFRESH_CYCLES (R),
        .GAP_CYCLES     (G),
        .ACTIVE_LOW     (1'b1),
        .BLANK_LZ       (1'b1),
        .CHECK_PARAM    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (clear),
        .load  (load),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an),
        .valid (valid)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    function automatic logic [6:0] inv(input logic [6:0] s);
        return ~s;
    endfunction

    // What the pins should show for scan time t with the model's held value.
    function automatic void disp(input bit act, input int t,
                                 output logic [6:0] s, output logic [3:0] a);
        int pos, ph;
        bit blk;
        s = 7'h7F;
        a = 4'hF;
        if (!act) return;
        pos = (t / (R + G)) % N;
        ph  = t % (R + G);
        if (ph >= R) return;
        blk = (pos > 0);
        for (int j = pos; j < N; j++) if (m_hold[j] != 4'd0) blk = 1'b0;
        if (blk) return;
        a = ~(4'b0001 << pos);
        s = ~ref_glyph(m_hold[pos]);
    endfunction

    task automatic model_reset();
        m_act   = 1'b0;
        m_t     = 0;
        m_valid = 1'b0;
        m_seg   = 7'h7F;
        m_an    = 4'hF;
        for (int i = 0; i < N; i++) m_hold[i] = 4'd0;
    endtask

    task automatic model_step();
        if (en) begin
            if (clear) begin
                m_act   = 1'b0;
                m_t     = 0;
                m_valid = 1'b0;
                m_seg   = 7'h7F;
                m_an    = 4'hF;
            end else begin
                disp(m_act, m_t, m_seg, m_an);
                if (load) begin
                    for (int i = 0; i < N; i++) m_hold[i] = bcd[i];
                    m_valid = 1'b1;
                    if (!m_act) begin
                        m_act = 1'b1;
                        m_t   = 0;
                    end else begin
                        m_t++;
                    end
                end else if (m_act) begin
                    m_t++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_seg", seg, m_seg);
        check("model_an", an, m_an);
        check("model_valid", valid, m_valid);
    endtask

    task automatic set_bcd(input logic [15:0] v);
        for (int i = 0; i < N; i++) bcd[i] = v[4*i +: 4];
    endtask

    task automatic load_val(input logic [15:0] v);
        set_bcd(v);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  obs_lit;
        logic [27:0] obs_seg;
        logic [6:0]  fz_seg;
        logic [3:0]  fz_an;
        int          waited;

        vt[0] = '{16'h0123, 4'b0111, {7'h00, 7'h06, 7'h5B, 7'h4F}};
        vt[1] = '{16'h0007, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h07}};
        vt[2] = '{16'h0000, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vt[3] = '{16'h00C0, 4'b0011, {7'h00, 7'h00, 7'h79, 7'h3F}};
        vt[4] = '{16'h9805, 4'b1111, {7'h6F, 7'h7F, 7'h3F, 7'h6D}};
        vt[5] = '{16'hF000, 4'b1111, {7'h79, 7'h3F, 7'h3F, 7'h3F}};
        slot_an = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                    4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE};

        rst_n = 1'b0; en = 1'b1; clear = 1'b0; load = 1'b0;
        set_bcd(16'h0000);
        model_reset();
        #12;
        check("reset_seg", seg, 7'h7F);
        check("reset_an", an, 4'hF);
        check("reset_valid", valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Vector table: one full refresh period per value, record what each position showed.
        for (int k = 0; k < 6; k++) begin
            do_clear();
            load_val(vt[k].digits);
            obs_lit = '0;
            obs_seg = '0;
            repeat (N * (R + G)) begin
                tick();
                for (int p = 0; p < N; p++) begin
                    if (an[p] == 1'b0) begin
                        obs_lit[p] = 1'b1;
                        obs_seg[7*p +: 7] = ~seg;
                    end
                end
            end
            check("vec_lit", obs_lit, vt[k].lit);
            check("vec_seg", obs_seg, vt[k].segs);
        end

        // Exact slot sequence and wrap for {0,1,2,3}.
        do_clear();
        load_val(16'h0123);
        check("load_valid", valid, 1'b1);
        check("load_dark", an, 4'hF);
        for (int i = 0; i < 21; i++) begin
            tick();
            check("slot_an", an, slot_an[i]);
            if (i == 0) check("slot0_seg", seg, inv(7'h4F));
        end

        // Load in the middle of the position-2 slot.
        waited = 0;
        while (an !== 4'b1011 && waited < 40) begin
            tick();
            waited++;
        end
        check("find_pos2", an, 4'b1011);
        set_bcd(16'h0523);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("midload_an1", an, 4'b1011);
        check("midload_old", seg, inv(7'h06));
        tick();
        check("midload_an2", an, 4'b1011);
        check("midload_new", seg, inv(7'h6D));
        tick();
        check("midload_an3", an, 4'b1011);
        tick();
        check("midload_gap", an, 4'hF);

        // Simultaneous clear and load.
        set_bcd(16'h4444);
        clear = 1'b1;
        load  = 1'b1;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        check("clrld_valid", valid, 1'b0);
        tick();
        check("clrld_an", an, 4'hF);
        check("clrld_seg", seg, 7'h7F);

        // Freeze with en=0 mid-slot, including an ignored load.
        do_clear();
        load_val(16'h0123);
        repeat (7) tick();
        fz_seg = seg;
        fz_an  = an;
        check("freeze_pre", an, 4'b1101);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                set_bcd(16'h9999);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            check("freeze_seg", seg, fz_seg);
            check("freeze_an", an, fz_an);
        end
        load = 1'b0;
        en   = 1'b1;
        tick();
        check("resume1_an", an, 4'b1101);
        check("resume1_seg", seg, inv(7'h5B));
        tick();
        check("resume2_an", an, 4'b1101);
        tick();
        check("resume_gap", an, 4'hF);

        // Asynchronous reset while a digit is lit.
        waited = 0;
        while (an === 4'hF && waited < 20) begin
            tick();
            waited++;
        end
        check("rst_lit_found", (an !== 4'hF), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_seg", seg, 7'h7F);
        check("rst_mid_an", an, 4'hF);
        check("rst_mid_valid", valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            en    = ($urandom_range(0, 7) != 0);
            load  = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++)
                bcd[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed 7-segment driver sitting directly downstream of the binary-to-BCD converter. It captures the converter's BCD digit array on its one-cycle done pulse and continuously scans the digits onto a shared segment bus with one-hot digit enables. It also provides leading-zero blanking, an inter-digit ghosting gap and an error glyph for non-BCD nibbles. The multiplier result path ends here, at the board display.

## Interface
- NUM_DIGITS, 4: number of BCD digits and display positions; must match the converter's digit count.
- REFRESH_CYCLES, 50000: clock cycles a digit is driven; must be ≥1.
- GAP_CYCLES, 500: cycles all digits are off between digits; 0 disables the gap.
- ACTIVE_LOW, 1: 1 means seg and an are active-low; 0 means active-high.
- BLANK_LZ, 1: 1 enables leading-zero blanking.
- CHECK_PARAM, 1: enables simulation-only parameter checks.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 freezes all state and outputs.
- clear  in  1  synchronous return to IDLE; display goes dark.
- load  in  1  capture strobe, wired to the converter's done.
- bcd  in  [3:0] x NUM_DIGITS (unpacked)  digit array; bcd[0] is the ones digit.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- an  out  NUM_DIGITS  digit enables; an[i] drives position i (position 0 is rightmost).
- valid  out  1  1 while a captured value is being displayed.

## Operation
- Hold register: on `en & load & ~clear`, bcd is copied into the hold register and valid is set to 1.
- States:
  - IDLE: no value held; all digits off.
  - SHOW: the digit at the current index is driven.
  - GAP: all digits off.
- IDLE → SHOW with index 0 and counter 0 on load.
- SHOW → GAP when the counter reaches REFRESH_CYCLES-1. If GAP_CYCLES=0, go straight to SHOW with the next index.
- GAP → SHOW with the next index when the counter reaches GAP_CYCLES-1.
- The counter resets to 0 on every state change.
- Next index = (index+1) mod NUM_DIGITS; it wraps from NUM_DIGITS-1 to 0.
- Load while in SHOW or GAP: the hold register updates, but state, index and counter are unchanged. There is no restart of the scan.
- clear from any state: go to IDLE, set index and counter to 0, set valid to 0. clear wins over a simultaneous load.
- en=0: nothing changes. A load is ignored even if it coincides with en=0.
- Decode, in active-high form:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Nibbles 10–15 decode to 0x79 ('E').
- Leading-zero blanking: digit i (i>0) is blanked when BLANK_LZ=1 and hold[j]==0 for all j≥i. Digit 0 is never blanked. A blanked digit keeps its enable deasserted for its whole SHOW slot; timing is unchanged.
- Output polarity: seg and an are inverted when ACTIVE_LOW=1.
- Digit enables: an is one-hot in SHOW (unless the digit is blanked). It is all-off in IDLE and GAP.

## Timing
- Reset values:
  - state=IDLE, index=0, counter=0, hold=0, valid=0.
  - seg: all segments off (7'h7F when ACTIVE_LOW).
  - an: all off (all ones when ACTIVE_LOW).
- seg and an are registered. They reflect the state, index and hold register of the previous cycle.
- Load sampled at edge k:
  - state=SHOW and valid=1 after edge k.
  - Digit 0 appears on seg/an after edge k+1.
- Load during a SHOW slot: the new value appears on the pins two edges after the load edge.
- Full refresh period = NUM_DIGITS × (REFRESH_CYCLES + GAP_CYCLES) cycles.
- Reset asserted mid-scan: all state and outputs go to their reset values immediately, with no clock required.

## Structure
- Package bcd_display_pkg:
  - state enum typedef (IDLE, SHOW, GAP);
  - segment constants and the glyph-decode function;
  - SEG_ERR constant;
  - clog2-based width helper for the counter.
- Sub-module bcd_to_7seg: a combinational nibble-to-segment decoder in active-high form. It is instantiated once, fed by the hold digit selected by index.
- CHECK_PARAM reports a fatal error when NUM_DIGITS<1 or REFRESH_CYCLES<1.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_CYCLES=4, GAP_CYCLES=1, ACTIVE_LOW=1, BLANK_LZ=1.
- Reset → seg=7'h7F, an=4'hF, valid=0. Assert rst_n low mid-scan → the same values immediately, with no clock edge.
- Load {0,1,2,3} (bcd[0]=3): the slot sequence must be:
  - an=4'b1110 with seg=~0x4F for 4 cycles;
  - an=4'hF for 1 cycle;
  - an=4'b1101 with seg=~0x5B;
  - and so on.
  - Index wraps to 0 after 20 cycles.
- Load {0,0,0,7} → only the position-0 slot lights (seg=~0x07). Positions 1–3 stay an=4'hF. Load all zeros → position 0 shows ~0x3F.
- Load bcd[1]=4'hC → position 1 shows seg=~0x79.
- Load during the position-2 SHOW slot → the index and remaining slot count are unaffected, and the new digit 2 appears two edges later. A simultaneous clear+load → IDLE, valid=0, an=4'hF.
- en=0 for 10 cycles mid-slot → seg, an and the remaining dwell are frozen. A load pulse during that window is ignored.
